// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver: shadowed nibbles, one digit per DIV-cycle slot with a blank guard cycle.
// Optional leading-zero blanking is compiled in with `define SEG_SCAN_LZ_BLANK_EN.
module seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int DIV      = 1000,
  parameter int HEX_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int PW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

  logic [4*DIGITS-1:0] data_reg;
  logic [DIGITS-1:0]   dp_reg;
  logic [PW-1:0]       p_reg, p_next;
  logic [IW-1:0]       i_reg, i_next;
  logic [7:0]          seg_reg, seg_next;
  logic [DIGITS-1:0]   dig_sel_reg, dig_sel_next;
  logic                frame_done_reg, frame_done_next;

  logic                guard;
  logic [3:0]          nib [DIGITS];
  logic [DIGITS-1:0]   sel_onehot;
  logic [DIGITS-1:0]   blank_mask;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;

  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'h0: enc = 7'h3F;
      4'h1: enc = 7'h06;
      4'h2: enc = 7'h5B;
      4'h3: enc = 7'h4F;
      4'h4: enc = 7'h66;
      4'h5: enc = 7'h6D;
      4'h6: enc = 7'h7D;
      4'h7: enc = 7'h07;
      4'h8: enc = 7'h7F;
      4'h9: enc = 7'h6F;
      4'hA: enc = (HEX_MODE != 0) ? 7'h77 : 7'h00;
      4'hB: enc = (HEX_MODE != 0) ? 7'h7C : 7'h00;
      4'hC: enc = (HEX_MODE != 0) ? 7'h39 : 7'h00;
      4'hD: enc = (HEX_MODE != 0) ? 7'h5E : 7'h00;
      4'hE: enc = (HEX_MODE != 0) ? 7'h79 : 7'h00;
      default: enc = (HEX_MODE != 0) ? 7'h71 : 7'h00;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib[gi]        = data_reg[4*gi +: 4];
      assign sel_onehot[gi] = (i_reg == IW'(gi));
`ifdef SEG_SCAN_LZ_BLANK_EN
      // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
      if (gi == 0) begin : g_lsd
        assign blank_mask[gi] = 1'b0;
      end else begin : g_upper
        assign blank_mask[gi] = (data_reg[4*DIGITS-1:4*gi] == '0);
      end
`else
      assign blank_mask[gi] = 1'b0;
`endif
    end
  endgenerate

  assign cur_nib   = nib[i_reg];
  assign cur_dp    = dp_reg[i_reg];
  assign cur_blank = blank_mask[i_reg];
  assign guard     = (p_reg == P_LAST);

  // State register: shadow, scan counters and the registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg       <= '0;
      dp_reg         <= '0;
      p_reg          <= '0;
      i_reg          <= '0;
      seg_reg        <= 8'h00;
      dig_sel_reg    <= '1;
      frame_done_reg <= 1'b0;
    end else begin
      if (load) begin
        data_reg <= data;
        dp_reg   <= dp_in;
      end
      p_reg          <= p_next;
      i_reg          <= i_next;
      seg_reg        <= seg_next;
      dig_sel_reg    <= dig_sel_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Next-state: the prescaler wraps at DIV-1 and advances the digit index.
  always_comb begin
    p_next          = p_reg + 1'b1;
    i_next          = i_reg;
    frame_done_next = 1'b0;
    if (guard) begin
      p_next          = '0;
      i_next          = (i_reg == I_LAST) ? '0 : i_reg + 1'b1;
      frame_done_next = (i_reg == I_LAST);
    end
  end

  // Output decode: the last cycle of every slot is blanked so the old digit cannot ghost into the next.
  always_comb begin
    seg_next     = 8'h00;
    dig_sel_next = '1;
    if (!guard) begin
      dig_sel_next = ~sel_onehot;
      seg_next     = {cur_dp, cur_blank ? 7'h00 : enc(cur_nib)};
    end
  end

  assign seg        = seg_reg;
  assign dig_sel    = dig_sel_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a decimal and a hex instance share stimulus; a cycle-count model predicts every output.
module tb_seg_scan_driver;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [7:0]  seg0, seg1;
  logic [3:0]  dig0, dig1;
  logic        fd0, fd1;

  seg_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .HEX_MODE(0)) dut_dec (
    .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in),
    .seg(seg0), .dig_sel(dig0), .frame_done(fd0)
  );

  seg_scan_driver #(.DIGITS(DIGITS), .DIV(DIV), .HEX_MODE(1)) dut_hex (
    .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in),
    .seg(seg1), .dig_sel(dig1), .frame_done(fd1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot position is derived from the number of edges since reset.
  localparam logic [6:0] DEC_TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          n_edges;
  int          p_m, i_m;
  logic [15:0] sh_data;
  logic [3:0]  sh_dp;
  bit          model_valid = 0;
  logic [7:0]  exp_seg0, exp_seg1;
  logic [3:0]  exp_dig;
  logic        exp_fd;

  function automatic logic [7:0] model_seg(input int hex, input int idx,
                                           input logic [15:0] d, input logic [3:0] dp);
    logic [3:0] nibv;
    logic [6:0] s;
    logic [15:0] upper;
    nibv  = d[4*idx +: 4];
    s     = (hex == 0 && nibv > 4'd9) ? 7'h00 : DEC_TBL[nibv];
    upper = d >> (4*idx);
`ifdef SEG_SCAN_LZ_BLANK_EN
    if (idx > 0 && upper == 16'h0) s = 7'h00;
`endif
    return {dp[idx], s};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_seg0 = 8'h00; exp_seg1 = 8'h00; exp_dig = 4'hF; exp_fd = 1'b0;
      n_edges = 0; sh_data = 16'h0; sh_dp = 4'h0; model_valid = 1;
    end else if (model_valid) begin
      p_m = n_edges % DIV;
      i_m = (n_edges / DIV) % DIGITS;
      if (p_m == DIV - 1) begin
        exp_seg0 = 8'h00; exp_seg1 = 8'h00; exp_dig = 4'hF;
      end else begin
        exp_dig  = ~(4'b0001 << i_m);
        exp_seg0 = model_seg(0, i_m, sh_data, sh_dp);
        exp_seg1 = model_seg(1, i_m, sh_data, sh_dp);
      end
      exp_fd = (p_m == DIV - 1) && (i_m == DIGITS - 1);
      n_edges++;
      if (load) begin
        sh_data = data; sh_dp = dp_in;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_seg_dec", 16'(seg0), 16'(exp_seg0));
      check("model_seg_hex", 16'(seg1), 16'(exp_seg1));
      check("model_dig_dec", 16'(dig0), 16'(exp_dig));
      check("model_dig_hex", 16'(dig1), 16'(exp_dig));
      check("model_fd_dec",  16'(fd0),  16'(exp_fd));
      check("model_fd_hex",  16'(fd1),  16'(exp_fd));
    end
  end

  task automatic load_data(input logic [15:0] d, input logic [3:0] dp);
    @(negedge clk);
    data = d; dp_in = dp; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // e0/e1 hold expected seg bytes for the decimal/hex instance, digit k in bits [8k+7:8k].
  task automatic check_frame(input string tag, input logic [31:0] e0, input logic [31:0] e1);
    int w;
    logic [3:0] ed;
    w = 0;
    while (!fd0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_sync"}, 16'(fd0), 16'd1);
    for (int d = 0; d < DIGITS; d++) begin
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk);
        ed = (c < DIV - 1) ? ~(4'b0001 << d) : 4'hF;
        check({tag, "_dig"}, 16'(dig0), 16'(ed));
        check({tag, "_seg_dec"}, 16'(seg0), (c < DIV - 1) ? 16'(e0[8*d +: 8]) : 16'h0);
        check({tag, "_seg_hex"}, 16'(seg1), (c < DIV - 1) ? 16'(e1[8*d +: 8]) : 16'h0);
      end
    end
  endtask

  initial begin
    int w;
    // Reset values, then the first active cycle shows digit 0 = 0.
    repeat (3) begin
      @(negedge clk);
      check("rst_seg", 16'(seg0), 16'h00);
      check("rst_dig", 16'(dig0), 16'hF);
      check("rst_fd",  16'(fd0),  16'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_dig", 16'(dig0), 16'hE);
    check("post_rst_seg", 16'(seg0), 16'h3F);

    load_data(16'h1234, 4'h0);
    check_frame("scan1234", 32'h065B4F66, 32'h065B4F66);

    // frame_done cadence with load held high and random data.
    w = 0;
    while (!fd0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("fd_sync", 16'(fd0), 16'd1);
    for (int k = 1; k <= 48; k++) begin
      data = 16'($urandom); dp_in = 4'($urandom); load = 1'b1;
      @(negedge clk);
      check("fd_period", 16'(fd0), (k % 16 == 0) ? 16'd1 : 16'd0);
    end
    load = 1'b0;

    load_data(16'hAF0C, 4'b0100);
    check_frame("hex", 32'h0080_3F00, 32'h77F13F39);

`ifdef SEG_SCAN_LZ_BLANK_EN
    load_data(16'h0070, 4'h0);
    check_frame("lz0070", 32'h0000073F, 32'h0000073F);
    load_data(16'h0000, 4'h0);
    check_frame("lz0000", 32'h0000003F, 32'h0000003F);
`else
    load_data(16'h0070, 4'h0);
    check_frame("nolz0070", 32'h3F3F073F, 32'h3F3F073F);
    load_data(16'h0000, 4'h0);
    check_frame("nolz0000", 32'h3F3F3F3F, 32'h3F3F3F3F);
`endif

    // Reset in the middle of digit 2's slot.
    load_data(16'h5555, 4'h0);
    w = 0;
    while (dig0 != 4'b1011 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("mid_sync", 16'(dig0), 16'hB);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_dig", 16'(dig0), 16'hF);
    check("mid_rst_seg", 16'(seg0), 16'h00);
    rst = 1'b0;
    for (int c = 0; c < DIV; c++) begin
      @(negedge clk);
      check("mid_restart_dig", 16'(dig0), (c < DIV - 1) ? 16'hE : 16'hF);
      check("mid_restart_seg", 16'(seg0), (c < DIV - 1) ? 16'h3F : 16'h00);
    end

    // Random traffic, zero-heavy data to exercise blanking, occasional reset.
    repeat (1500) begin
      @(negedge clk);
      load  = ($urandom_range(0, 3) == 0);
      data  = 16'($urandom) & 16'($urandom) & 16'($urandom);
      dp_in = 4'($urandom);
      rst   = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
